// File: rtl/sap1_accumulator_stage_pkg.sv
// Shared constants for the SAP-1 accumulator stage: datapath width,
// micro-op encodings and FSM state encoding.
package sap1_accumulator_stage_pkg;

    localparam int WIDTH = 8;

    localparam logic [1:0] OP_LDA = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_OUT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EXEC     = 2'd1,
        ST_OUT_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/sap1_accumulator_stage_if.sv
// Micro-op and output handshakes of the accumulator stage, plus the
// architectural state (A and flags) it exposes.
interface sap1_accumulator_stage_if #(
    parameter int WIDTH = 8
);
    logic             op_valid;
    logic             op_ready;
    logic [1:0]       op_code;
    logic [WIDTH-1:0] op_data;
    logic [WIDTH-1:0] acc;
    logic             flag_c;
    logic             flag_z;
    logic             flag_v;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    // Side that issues micro-ops and consumes the output snapshot.
    modport master (
        output op_valid, op_code, op_data, out_ready,
        input  op_ready, acc, flag_c, flag_z, flag_v, out_valid, out_data
    );

    // The accumulator stage itself.
    modport slave (
        input  op_valid, op_code, op_data, out_ready,
        output op_ready, acc, flag_c, flag_z, flag_v, out_valid, out_data
    );
endinterface

// File: rtl/sap1_accumulator_stage_addsub.sv
// 8-bit adder/subtractor: s = a + (b ^ {8{cb}}) + cb.
// With cb=1 this is a - b and cout=1 means no borrow.
module Adder_Subtractor (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cb,
    output logic [7:0] s,
    output logic       cout
);
    logic [7:0] b_eff;

    assign b_eff     = b ^ {8{cb}};
    assign {cout, s} = {1'b0, a} + {1'b0, b_eff} + {8'd0, cb};
endmodule

// File: rtl/sap1_accumulator_stage.sv
// SAP-1 operand/accumulator stage: holds A and B, drives the shared
// adder/subtractor, writes the result back into A and keeps C/Z/V.
// One micro-op in flight at a time; OUT publishes an A snapshot.
module sap1_accumulator_stage
    import sap1_accumulator_stage_pkg::*;
#(
    parameter int WIDTH = sap1_accumulator_stage_pkg::WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    sap1_accumulator_stage_if.slave bus
);
    state_t           state, state_nxt;
    logic             started;
    logic             accept;
    logic             ld_a, ld_b, ld_out, wb, clr_out;

    logic [WIDTH-1:0] acc_r, b_reg, out_r;
    logic             sub_reg;
    logic             c_r, z_r, v_r, out_vld;

    logic [WIDTH-1:0] sum, b_eff;
    logic             cout, ovf;

    // op_ready stays low during reset and only rises after the first
    // clock edge following release, hence the separate started flag.
    assign bus.op_ready = started & (state == ST_IDLE);
    assign accept       = bus.op_valid & bus.op_ready;

    // Operand path into the adder is purely registered state.
    Adder_Subtractor u_addsub (
        .a    (acc_r),
        .b    (b_reg),
        .cb   (sub_reg),
        .s    (sum),
        .cout (cout)
    );

    assign b_eff = b_reg ^ {WIDTH{sub_reg}};
    assign ovf   = (acc_r[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != acc_r[WIDTH-1]);

    // State register and post-reset ready enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            started <= 1'b0;
        end else begin
            state   <= state_nxt;
            started <= 1'b1;
        end
    end

    // Next-state decode and datapath load enables.
    always_comb begin
        state_nxt = state;
        ld_a      = 1'b0;
        ld_b      = 1'b0;
        ld_out    = 1'b0;
        wb        = 1'b0;
        clr_out   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (bus.op_code)
                        OP_LDA: ld_a = 1'b1;
                        OP_ADD, OP_SUB: begin
                            ld_b      = 1'b1;
                            state_nxt = ST_EXEC;
                        end
                        default: begin
                            ld_out    = 1'b1;
                            state_nxt = ST_OUT_WAIT;
                        end
                    endcase
                end
            end
            ST_EXEC: begin
                wb        = 1'b1;
                state_nxt = ST_IDLE;
            end
            ST_OUT_WAIT: begin
                if (bus.out_ready) begin
                    clr_out   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Accumulator, operand, flag and output-snapshot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r   <= '0;
            b_reg   <= '0;
            sub_reg <= 1'b0;
            c_r     <= 1'b0;
            z_r     <= 1'b0;
            v_r     <= 1'b0;
            out_r   <= '0;
            out_vld <= 1'b0;
        end else begin
            if (ld_a) acc_r <= bus.op_data;
            if (ld_b) begin
                b_reg   <= bus.op_data;
                sub_reg <= (bus.op_code == OP_SUB);
            end
            if (wb) begin
                acc_r <= sum;
                c_r   <= cout;
                z_r   <= (sum == '0);
                v_r   <= ovf;
            end
            if (ld_out) begin
                out_r   <= acc_r;
                out_vld <= 1'b1;
            end
            if (clr_out) out_vld <= 1'b0;
        end
    end

    assign bus.acc       = acc_r;
    assign bus.flag_c    = c_r;
    assign bus.flag_z    = z_r;
    assign bus.flag_v    = v_r;
    assign bus.out_valid = out_vld;
    assign bus.out_data  = out_r;

endmodule
